ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_keyboard_rx_if.sv | 32 +++
 rtl/ps2_scan_to_ascii.sv | 61 ++++++
 rtl/ps2_keyboard_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path: FSM state encoding,
// PS/2 prefix byte values, ASCII control codes and the frame parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } ps2State_t;

  localparam logic [7:0] PS2_BREAK       = 8'hF0;
  localparam logic [7:0] PS2_EXT         = 8'hE0;

  localparam logic [7:0] ASCII_ENTER     = 8'd13;
  localparam logic [7:0] ASCII_BACKSPACE = 8'd8;
  localparam logic [7:0] ASCII_SPACE     = 8'd32;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx_if
// Bundles the PS/2 pins and the keyboard-register side outputs.
//   ps2_clk, ps2_data : raw asynchronous PS/2 pins
//   key_reg           : ASCII of the last accepted key
//   sample            : toggles once per accepted key
//   scan_code         : last correctly framed raw byte
//   frame_error       : one-cycle error pulse
//   busy              : receiver is mid-frame
// master = the receiver, slave = whoever drives the pins / consumes results.
// ---------------------------------------------------------------------------
interface ps2_keyboard_rx_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_reg;
  logic       sample;
  logic [7:0] scan_code;
  logic       frame_error;
  logic       busy;

  modport master (
    input  ps2_clk, ps2_data,
    output key_reg, sample, scan_code, frame_error, busy
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_reg, sample, scan_code, frame_error, busy
  );

endinterface

// File: rtl/ps2_scan_to_ascii.sv
// ---------------------------------------------------------------------------
// ps2_scan_to_ascii
// Purely combinational translation of a PS/2 set-2 make code to ASCII.
//   scanCode : 8-bit make code
//   ascii    : ASCII result, 8'd0 for any key without a mapping
// ---------------------------------------------------------------------------
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scanCode,
  output logic [7:0] ascii
);

  // Lookup table: digits, lowercase letters, space/enter/backspace.
  always_comb begin
    ascii = 8'd0;
    case (scanCode)
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h29: ascii = ASCII_SPACE;
      8'h5A: ascii = ASCII_ENTER;
      8'h66: ascii = ASCII_BACKSPACE;
      default: ascii = 8'd0;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
// PS/2 keyboard receiver feeding the Memory keyboard register. Synchronises
// the PS/2 pins, deserialises 11-bit frames on ps2_clk falling edges, tracks
// break (F0) / extended (E0) prefixes and publishes translated make codes.
//   clock : core clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : ps2_keyboard_rx_if.master (pins in, key_reg/sample/scan_code/
//           frame_error/busy out; all outputs registered)
// ---------------------------------------------------------------------------
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clkSync_r;
  logic [SYNC_STAGES-1:0] dataSync_r;
  logic                   clkPrev_r;
  logic                   clkCur_s;
  logic                   dataCur_s;
  logic                   fall_s;

  ps2State_t              state_r;
  ps2State_t              nextState_s;
  logic                   abort_s;

  logic [7:0]             shift_r;
  logic [2:0]             bitCnt_r;
  logic                   parity_r;
  logic [TW-1:0]          toCnt_r;
  logic                   timedOut_s;

  logic                   brk_r;
  logic                   ext_r;
  logic [7:0]             key_r;
  logic                   sample_r;
  logic [7:0]             scan_r;
  logic                   frameErr_r;
  logic                   busy_r;

  logic                   brkNext_s;
  logic                   extNext_s;
  logic [7:0]             keyNext_s;
  logic                   sampleNext_s;
  logic [7:0]             scanNext_s;
  logic [7:0]             ascii_s;

  assign clkCur_s   = clkSync_r[SYNC_STAGES-1];
  assign dataCur_s  = dataSync_r[SYNC_STAGES-1];
  assign fall_s     = clkPrev_r & ~clkCur_s;
  assign timedOut_s = (toCnt_r == TO_MAX);

  ps2_scan_to_ascii uXlate (
    .scanCode (shift_r),
    .ascii    (ascii_s)
  );

  // Pin synchronisers plus previous-clock register for falling-edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clkSync_r  <= '0;
      dataSync_r <= '0;
      clkPrev_r  <= 1'b0;
    end else begin
      clkSync_r  <= {clkSync_r[SYNC_STAGES-2:0], bus.ps2_clk};
      dataSync_r <= {dataSync_r[SYNC_STAGES-2:0], bus.ps2_data};
      clkPrev_r  <= clkCur_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next state; a fall always wins over a simultaneous timeout.
  always_comb begin
    nextState_s = state_r;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s && !dataCur_s) begin
          nextState_s = DATA;
        end else begin
          nextState_s = IDLE;
        end
      end
      DATA: begin
        if (fall_s) begin
          nextState_s = (bitCnt_r == 3'd7) ? PARITY : DATA;
        end else if (timedOut_s) begin
          nextState_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          nextState_s = DATA;
        end
      end
      PARITY: begin
        if (fall_s) begin
          nextState_s = STOP;
        end else if (timedOut_s) begin
          nextState_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          nextState_s = PARITY;
        end
      end
      STOP: begin
        if (fall_s) begin
          if (dataCur_s && oddParityOk(shift_r, parity_r)) begin
            nextState_s = DONE;
          end else begin
            nextState_s = IDLE;
            abort_s     = 1'b1;
          end
        end else if (timedOut_s) begin
          nextState_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          nextState_s = STOP;
        end
      end
      DONE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // FSM outputs: what the completed byte does to the prefix flags and key register.
  always_comb begin
    brkNext_s    = brk_r;
    extNext_s    = ext_r;
    keyNext_s    = key_r;
    sampleNext_s = sample_r;
    scanNext_s   = scan_r;
    if (state_r == DONE) begin
      scanNext_s = shift_r;
      if (shift_r == PS2_BREAK) begin
        brkNext_s = 1'b1;
      end else if (shift_r == PS2_EXT) begin
        extNext_s = 1'b1;
      end else if (brk_r || ext_r) begin
        // Byte following a prefix (release or extended key) is consumed silently.
        brkNext_s = 1'b0;
        extNext_s = 1'b0;
      end else if (ascii_s != 8'd0) begin
        keyNext_s    = ascii_s;
        sampleNext_s = ~sample_r;
      end else begin
        keyNext_s = key_r;
      end
    end else begin
      scanNext_s = scan_r;
    end
  end

  // Frame datapath: bit counter, LSB-first shifter, parity capture, timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_r  <= 8'd0;
      bitCnt_r <= 3'd0;
      parity_r <= 1'b0;
      toCnt_r  <= '0;
    end else begin
      if (fall_s) begin
        case (state_r)
          IDLE: begin
            bitCnt_r <= 3'd0;
          end
          DATA: begin
            shift_r  <= {dataCur_s, shift_r[7:1]};
            bitCnt_r <= bitCnt_r + 3'd1;
          end
          PARITY: begin
            parity_r <= dataCur_s;
          end
          default: begin
            parity_r <= parity_r;
          end
        endcase
      end
      // Saturating count of cycles since the last fall; idle line never times out.
      if (fall_s || (state_r == IDLE)) begin
        toCnt_r <= '0;
      end else if (!timedOut_s) begin
        toCnt_r <= toCnt_r + TW'(1);
      end
    end
  end

  // Registered outputs and prefix flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      brk_r      <= 1'b0;
      ext_r      <= 1'b0;
      key_r      <= 8'd0;
      sample_r   <= 1'b0;
      scan_r     <= 8'd0;
      frameErr_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      brk_r      <= brkNext_s;
      ext_r      <= extNext_s;
      key_r      <= keyNext_s;
      sample_r   <= sampleNext_s;
      scan_r     <= scanNext_s;
      frameErr_r <= abort_s;
      busy_r     <= (nextState_s != IDLE);
    end
  end

  assign bus.key_reg     = key_r;
  assign bus.sample      = sample_r;
  assign bus.scan_code   = scan_r;
  assign bus.frame_error = frameErr_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Drives PS/2 frames into ps2_keyboard_rx, keeps a reference model of the
// keyboard protocol and scores every sample toggle against expected ASCII.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

  localparam int TO = 300;  // shortened timeout so the abort path is reachable
  localparam int H  = 20;   // core cycles per PS/2 clock half-period

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ps2_keyboard_rx_if bus();

  ps2_keyboard_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int expErr  = 0;
  int errSeen = 0;

  logic [7:0] expQ[$];
  logic       brk = 1'b0;
  logic       ext = 1'b0;
  logic [7:0] lastScan = 8'd0;
  logic [7:0] lastKey  = 8'd0;

  logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Key position in the digit row / alphabet gives the ASCII value directly.
  function automatic logic [7:0] refAscii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'd0;
    for (int i = 0; i < 10; i++) if (digitCodes[i] == code) a = 8'd48 + 8'(i);
    for (int i = 0; i < 26; i++) if (letterCodes[i] == code) a = 8'd97 + 8'(i);
    if (code == 8'h29) a = 8'd32;
    if (code == 8'h5A) a = 8'd13;
    if (code == 8'h66) a = 8'd8;
    return a;
  endfunction

  task automatic modelFrame(input logic [7:0] b);
    logic [7:0] a;
    lastScan = b;
    if (b == 8'hF0) brk = 1'b1;
    else if (b == 8'hE0) ext = 1'b1;
    else if (brk || ext) begin
      brk = 1'b0;
      ext = 1'b0;
    end else begin
      a = refAscii(b);
      if (a != 8'd0) begin
        expQ.push_back(a);
        lastKey = a;
      end
    end
  endtask

  task automatic driveBit(input logic v);
    @(negedge clock);
    bus.ps2_data = v;
    repeat (H) @(negedge clock);
    bus.ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic badStop);
    if (badPar || badStop) expErr++;
    else modelFrame(b);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit((~^b) ^ badPar);
    driveBit(~badStop);
    bus.ps2_data = 1'b1;
    repeat (2 * H) @(negedge clock);
    check("scan_code", bus.scan_code, lastScan);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clock);
    check("queue_drained", expQ.size(), 0);
  endtask

  task automatic checkResetOutputs();
    check("reset_key_reg", bus.key_reg, 8'd0);
    check("reset_sample", bus.sample, 1'b0);
    check("reset_scan_code", bus.scan_code, 8'd0);
    check("reset_frame_error", bus.frame_error, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every sample toggle; measures error pulses.
  logic monPrev = 1'b0;
  int   feRun   = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        monPrev = 1'b0;
        feRun   = 0;
      end else begin
        if (bus.sample !== monPrev) begin
          monPrev = bus.sample;
          if (expQ.size() == 0) begin
            check("strobe_without_key", expQ.size(), 1);
          end else begin
            check("key_reg", bus.key_reg, expQ.pop_front());
          end
        end
        if (bus.frame_error === 1'b1) begin
          feRun++;
        end else if (feRun != 0) begin
          errSeen++;
          check("frame_error_width", feRun, 1);
          feRun = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    int r2;
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    checkResetOutputs();
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // Directed sequences.
    sendFrame(8'h16, 1'b0, 1'b0);
    sendFrame(8'h1E, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b0);
    sendFrame(8'h1E, 1'b0, 1'b0);
    sendFrame(8'h26, 1'b1, 1'b0);
    sendFrame(8'h26, 1'b0, 1'b0);

    // Partial frame then silence: timeout abort.
    b = 8'h25;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(b[i]);
    check("busy_mid_frame", bus.busy, 1'b1);
    expErr++;
    for (int i = 0; i < TO + 100 && bus.busy === 1'b1; i++) @(negedge clock);
    check("busy_after_timeout", bus.busy, 1'b0);
    repeat (10) @(negedge clock);
    sendFrame(8'h25, 1'b0, 1'b0);

    sendFrame(8'hE0, 1'b0, 1'b0);
    sendFrame(8'h75, 1'b0, 1'b0);
    sendFrame(8'h76, 1'b0, 1'b0);
    sendFrame(8'h2E, 1'b0, 1'b0);
    sendFrame(8'h45, 1'b0, 1'b1);

    // A falling edge with data high in idle is not a start bit.
    bus.ps2_data = 1'b1;
    bus.ps2_clk  = 1'b0;
    repeat (H) @(negedge clock);
    check("idle_fall_data_high_busy", bus.busy, 1'b0);
    bus.ps2_clk = 1'b1;
    repeat (H) @(negedge clock);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      if (r < 30) b = letterCodes[$urandom_range(0, 25)];
      else if (r < 50) b = digitCodes[$urandom_range(0, 9)];
      else if (r < 65) b = 8'hF0;
      else if (r < 75) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      sendFrame(b, (r2 < 10), (r2 >= 10 && r2 < 15));
    end

    // Reset in the middle of a frame.
    waitDrain();
    b = 8'h16;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(b[i]);
    check("busy_before_reset", bus.busy, 1'b1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 checkResetOutputs();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    brk      = 1'b0;
    ext      = 1'b0;
    lastScan = 8'd0;
    lastKey  = 8'd0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    sendFrame(8'h16, 1'b0, 1'b0);

    waitDrain();
    repeat (50) @(negedge clock);
    check("frame_error_count", errSeen, expErr);
    check("final_key_reg", bus.key_reg, lastKey);
    check("final_scan_code", bus.scan_code, lastScan);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
